// File: rtl/dcache_pkg.sv
// Shared constants and types for the direct-mapped write-through data cache.
// Address split: tag = addr[31:10], index = addr[9:2], offset = addr[1:0].
package dcache_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INDEX_BITS  = 8;
    localparam int OFFSET_BITS = 2;
    localparam int TAG_BITS    = DATA_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_SETS    = 1 << INDEX_BITS;
    localparam int LINE_BYTES  = 1 << OFFSET_BITS;

    // Data memory window; anything outside bypasses the cache.
    localparam logic [DATA_WIDTH-1:0] DMEM_LO = 32'h0000_0100;
    localparam logic [DATA_WIDTH-1:0] DMEM_HI = 32'h0001_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } dcache_state_t;

    function automatic logic is_cacheable(input logic [DATA_WIDTH-1:0] addr);
        return (addr >= DMEM_LO) && (addr <= DMEM_HI);
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data storage for the data cache: one combinational read port,
// a store-hit byte write, a fill byte write, a line-valid/tag set, and a
// flash clear of all valid bits on reset.
module dcache_store
    import dcache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    // read / lookup port
    input  logic [INDEX_BITS-1:0]  i_rd_index,
    input  logic [OFFSET_BITS-1:0] i_rd_offset,
    input  logic [TAG_BITS-1:0]    i_rd_tag,
    output logic                   o_hit,
    output logic [7:0]             o_rd_byte,
    // store-hit byte write
    input  logic                   i_st_we,
    input  logic [INDEX_BITS-1:0]  i_st_index,
    input  logic [OFFSET_BITS-1:0] i_st_offset,
    input  logic [7:0]             i_st_byte,
    // fill byte write
    input  logic                   i_fill_we,
    input  logic [INDEX_BITS-1:0]  i_fill_index,
    input  logic [OFFSET_BITS-1:0] i_fill_offset,
    input  logic [7:0]             i_fill_byte,
    // line completion: mark valid and record tag
    input  logic                   i_line_set,
    input  logic [INDEX_BITS-1:0]  i_line_index,
    input  logic [TAG_BITS-1:0]    i_line_tag
);

    logic [NUM_SETS-1:0] r_valid;
    logic [TAG_BITS-1:0] r_tag  [NUM_SETS];
    logic [7:0]          r_data [NUM_SETS*LINE_BYTES];

    // Valid bits: flash-cleared on reset, set when a fill completes.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_line_set) begin
            r_valid[i_line_index] <= 1'b1;
        end
    end

    // Tag array: written once per completed fill.
    // NOTE: tag and data arrays are deliberately not reset -- the valid bits
    // gate every lookup, and resetting RAM contents would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (i_line_set) begin
            r_tag[i_line_index] <= i_line_tag;
        end
    end

    // Data array: fill bytes and store-hit bytes (never both in one cycle).
    always_ff @(posedge clk) begin
        if (i_fill_we) begin
            r_data[{i_fill_index, i_fill_offset}] <= i_fill_byte;
        end else if (i_st_we) begin
            r_data[{i_st_index, i_st_offset}] <= i_st_byte;
        end
    end

    assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
    assign o_rd_byte = r_data[{i_rd_index, i_rd_offset}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate byte cache between the CPU
// memory stage and byte-addressed data memory. LBU hits are served with zero
// latency; a read miss stalls while the 4-byte line is fetched one byte per
// cycle (5 stall cycles total). SB is always forwarded to memory.
// Optional hit/miss statistics counters: define DATA_CACHE_STATS_EN.
module data_cache
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  stall,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic [DATA_WIDTH-1:0] hit_count,
    output logic [DATA_WIDTH-1:0] miss_count
);

    dcache_state_t          r_state;
    dcache_state_t          w_next_state;
    logic [1:0]             r_cnt;
    logic [INDEX_BITS-1:0]  r_fill_index;
    logic [TAG_BITS-1:0]    r_fill_tag;

    logic [OFFSET_BITS-1:0] w_offset;
    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic                   w_cacheable;
    logic                   w_hit;
    logic [7:0]             w_hit_byte;
    logic                   w_start_fill;
    logic                   w_store_hit_we;
    logic                   w_fill_we;
    logic                   w_line_set;
    logic                   w_unused_wd;

    assign w_offset    = cpu_addr[OFFSET_BITS-1:0];
    assign w_index     = cpu_addr[OFFSET_BITS +: INDEX_BITS];
    assign w_tag       = cpu_addr[DATA_WIDTH-1 -: TAG_BITS];
    assign w_cacheable = is_cacheable(cpu_addr);
    // Only the low byte of store data is meaningful for SB.
    assign w_unused_wd = ^cpu_wd[DATA_WIDTH-1:8];

    dcache_store u_store (
        .clk           (clk),
        .rst           (rst),
        .i_rd_index    (w_index),
        .i_rd_offset   (w_offset),
        .i_rd_tag      (w_tag),
        .o_hit         (w_hit),
        .o_rd_byte     (w_hit_byte),
        .i_st_we       (w_store_hit_we),
        .i_st_index    (w_index),
        .i_st_offset   (w_offset),
        .i_st_byte     (cpu_wd[7:0]),
        .i_fill_we     (w_fill_we),
        .i_fill_index  (r_fill_index),
        .i_fill_offset (r_cnt),
        .i_fill_byte   (mem_rd[7:0]),
        .i_line_set    (w_line_set),
        .i_line_index  (r_fill_index),
        .i_line_tag    (r_fill_tag)
    );

    // FSM state and fill counter; reset abandons any partial fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            if (w_start_fill) begin
                r_cnt <= 2'd0;
            end else if (r_state == FILL) begin
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    // Miss line address, captured in the miss cycle; meaningful only in FILL.
    always_ff @(posedge clk) begin
        if (w_start_fill) begin
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
        end
    end

    // Next-state, memory-side muxing and CPU response.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        w_next_state   = r_state;
        w_start_fill   = 1'b0;
        w_store_hit_we = 1'b0;
        w_fill_we      = 1'b0;
        w_line_set     = 1'b0;
        stall          = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = cpu_addr;
        mem_wd         = {24'b0, cpu_wd[7:0]};
        cpu_rd         = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (cpu_we) begin
                        mem_we         = 1'b1;
                        w_store_hit_we = w_cacheable && w_hit;
                    end else if (cpu_re) begin
                        if (!w_cacheable) begin
                            cpu_rd = mem_rd;
                        end else if (w_hit) begin
                            cpu_rd = {24'b0, w_hit_byte};
                        end else begin
                            stall        = 1'b1;
                            w_start_fill = 1'b1;
                            w_next_state = FILL;
                        end
                    end
                end
                FILL: begin
                    stall     = 1'b1;
                    mem_addr  = {r_fill_tag, r_fill_index, r_cnt};
                    w_fill_we = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_line_set   = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            endcase
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic                  w_load_hit;
    logic [DATA_WIDTH-1:0] r_hit_count;
    logic [DATA_WIDTH-1:0] r_miss_count;

    assign w_load_hit = !rst && (r_state == IDLE) && !cpu_we && cpu_re
                        && w_cacheable && w_hit;

    // Load-hit and miss statistics, wrapping modulo 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_load_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start_fill) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
